// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit sequencing logic: the FSM state
// encoding, the data-bit count and the frame-length constants.
//
// Configuration macro: UART_TX_STOP2_EN
//   defined   -> two stop bits per frame
//   undefined -> one stop bit per frame (default)
// ---------------------------------------------------------------------------
package uart_pkg;

    // Sequencing states of the transmit controller
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BIT_CNT_W = 3;

`ifdef UART_TX_STOP2_EN
    localparam int UART_STOP_BITS = 2;
`else
    localparam int UART_STOP_BITS = 1;
`endif

    // start bit + data bits + stop bit(s)
    localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Handshake bundle between the TBR/TSR register stage and the transmit
// sequencing controller.
//
// Signals:
//   tbr_valid    register stage -> ctrl : one-cycle pulse, TBR holds a new byte
//   load         ctrl -> datapath       : TSR <= {stop, TBR, start}
//   shift        ctrl -> datapath       : TSR shift right, fill with 1
//   set          ctrl -> datapath       : force the serial line high
//   clear_valid  ctrl -> register stage : clear the register-stage valid
//   tx_ready     ctrl -> CPU side       : no byte pending, TBR may be written
//   tx_busy      ctrl -> CPU side       : frame in progress
//   tx_done      ctrl -> CPU side       : pulse in last cycle of the stop period
//   tx_overrun   ctrl -> CPU side       : pulse, a byte arrived while one pending
//
// Modports: master = register stage / datapath side, slave = controller.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;

    logic tbr_valid;
    logic load;
    logic shift;
    logic set;
    logic clear_valid;
    logic tx_ready;
    logic tx_busy;
    logic tx_done;
    logic tx_overrun;

    modport master (
        output tbr_valid,
        input  load,
        input  shift,
        input  set,
        input  clear_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_overrun
    );

    modport slave (
        input  tbr_valid,
        output load,
        output shift,
        output set,
        output clear_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_overrun
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Baud-period counter. Counts 0 .. CLKS_PER_BIT-1 while enabled and wraps to
// 0 only after the terminal count. A synchronous clear holds it at 0.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
// Ports:
//   clk     in  clock, rising edge
//   reset   in  async, active-high
//   clear   in  synchronous clear to 0 (wins over enable)
//   enable  in  advance the count
//   tc      out count is at CLKS_PER_BIT-1 (decoded from the register)
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868,
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] baud_cnt;

    // Terminal count is decoded from the counter register only
    assign tc = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Counter register: clear has priority, otherwise count and wrap at tc
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (clear) begin
            baud_cnt <= '0;
        end else if (enable) begin
            if (tc) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Sequencing FSM for the 8N1 UART transmit datapath. It drives the TBR/TSR
// Load/Shift/Set/Clear_Valid strobes, times each bit with uart_baud_cnt,
// counts data bits, latches the one-cycle TBR-valid pulse into a pending
// flag and reports ready/busy/done/overrun to the CPU-side write logic.
// Every output is decoded from registered state; no input reaches an output
// combinationally.
//
// Configuration macro: UART_TX_STOP2_EN (two stop bits when defined).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2), default 868
// Ports:
//   clk    in  clock, rising edge
//   reset  in  async, active-high; aborts any frame, drops the pending byte
//   bus    uart_tx_ctrl_if.slave (tbr_valid in; strobes and status out)
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_ctrl_if.slave  bus
);

    uart_state_t                state;
    uart_state_t                next_state;
    logic                       pending;
    logic                       overrun_q;
    logic [UART_BIT_CNT_W-1:0]  bit_cnt;
    logic                       baud_tc;
    logic                       baud_clear;
    logic                       baud_en;
    logic                       in_load;
    logic                       last_data_bit;
    logic                       stop_last;

    assign in_load    = (state == LOAD);
    assign baud_clear = (state == IDLE) || (state == LOAD);
    assign baud_en    = (state == START) || (state == DATA) || (state == STOP);

    // bit_cnt doubles as the stop-bit index inside STOP, so the last stop
    // cycle is the terminal count of stop bit UART_STOP_BITS-1
    assign last_data_bit = (bit_cnt == UART_BIT_CNT_W'(UART_DATA_BITS - 1));
    assign stop_last     = baud_tc && (bit_cnt == UART_BIT_CNT_W'(UART_STOP_BITS - 1));

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .enable (baud_en),
        .tc     (baud_tc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a pending byte is picked up from IDLE or straight
    // from the end of the stop period, giving one idle-high LOAD cycle
    // between back-to-back frames
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pending) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = START;
            end
            START: begin
                if (baud_tc) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (baud_tc && last_data_bit) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (stop_last) begin
                    next_state = pending ? LOAD : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from state and counter registers
    always_comb begin
        bus.load        = 1'b0;
        bus.shift       = 1'b0;
        bus.set         = 1'b0;
        bus.clear_valid = 1'b0;
        bus.tx_busy     = 1'b0;
        bus.tx_done     = 1'b0;
        case (state)
            IDLE: begin
                bus.set = 1'b1;
            end
            LOAD: begin
                bus.load        = 1'b1;
                bus.clear_valid = 1'b1;
                bus.set         = 1'b1;
            end
            START, DATA: begin
                bus.shift   = baud_tc;
                bus.tx_busy = 1'b1;
            end
            STOP: begin
                bus.tx_busy = 1'b1;
                bus.tx_done = stop_last;
            end
            default: begin
                bus.set = 1'b1;
            end
        endcase
        bus.tx_ready   = ~pending;
        bus.tx_overrun = overrun_q;
    end

    // Pending flag: a new byte wins over a simultaneous load so it is not
    // lost. A byte arriving while one is already waiting (and not being
    // loaded this cycle) is flagged as an overrun on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= bus.tbr_valid && pending && !in_load;
            if (bus.tbr_valid) begin
                pending <= 1'b1;
            end else if (in_load) begin
                pending <= 1'b0;
            end
        end
    end

    // Bit counter: restarted by the start-bit shift, advanced by each data
    // shift (wrapping 7 -> 0 into STOP) and by each completed stop bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else begin
            case (state)
                START: begin
                    if (baud_tc) begin
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tc && !stop_last) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule
